// File: rtl/dispatch_pkg.sv
// Shared constants and types for the dispatch queue controller.
//   DATA_W  : instruction width
//   DEPTH   : entries per core queue (power of 2, >= 2)
//   ADDR_W  : log2(DEPTH); occupancy counters are ADDR_W+1 bits
//   entry_t : one queue slot, {fence, instr}; fences carry instr = 0
package dispatch_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              fence;
    logic [DATA_W-1:0] instr;
  } entry_t;

  // Build the slot written for an arbiter entry.
  function automatic entry_t make_entry(input logic is_fence, input logic [DATA_W-1:0] instr);
    entry_t e;
    e.fence = is_fence;
    e.instr = is_fence ? '0 : instr;
    return e;
  endfunction

endpackage

// File: rtl/dispatch_queue_ctrl_fifo.sv
// instr_fifo: synchronous FIFO of entry_t, DEPTH entries.
//   clk, reset : clock, synchronous active-high reset
//   push       : write wr_data (ignored when full)
//   wr_data    : entry to write
//   pop        : discard the head (ignored when empty)
//   head       : entry at the read pointer, straight from storage
//   count      : occupancy, 0..DEPTH
//   full/empty : count == DEPTH / count == 0
module instr_fifo
  import dispatch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  entry_t          wr_data,
  input  logic            pop,
  output entry_t          head,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  entry_t            mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are ADDR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/empty mask stale slots,
  // and leaving it out of reset lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dispatch_queue_ctrl.sv
// dispatch_queue_ctrl: buffers arbiter instructions in two per-core queues
// and issues them over valid/ready, with a fence barrier across both cores.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : arbiter handshake
//   in_instr            : instruction from the arbiter
//   in_core_sel         : 0 = core 1, 1 = core 2 (ignored for fences)
//   in_fence            : entry is a barrier, written to both queues
//   coreN_instr/valid   : head instruction offered to core N
//   coreN_ready         : core N consumes the head
//   count1/count2       : queue occupancy, fences included
//   fence_done          : one-cycle pulse the cycle after a fence retires
// Widths come from dispatch_pkg.
module dispatch_queue_ctrl
  import dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  input  logic              in_core_sel,
  input  logic              in_fence,
  output logic              in_ready,
  output logic [DATA_W-1:0] core1_instr,
  output logic              core1_valid,
  input  logic              core1_ready,
  output logic [DATA_W-1:0] core2_instr,
  output logic              core2_valid,
  input  logic              core2_ready,
  output logic [ADDR_W:0]   count1,
  output logic [ADDR_W:0]   count2,
  output logic              fence_done
);

  entry_t head1, head2, wr_entry;
  logic   full1, full2, empty1, empty2;
  logic   push1, push2, pop1, pop2;
  logic   accept;
  logic   fence_retire;
  logic   accept_en;

  // Holds in_ready low through reset and raises it the cycle after reset drops.
  always_ff @(posedge clk) begin
    if (reset) accept_en <= 1'b0;
    else       accept_en <= 1'b1;
  end

  // in_ready looks only at registered occupancy: a same-cycle pop never
  // frees a slot for the push.
  always_comb begin
    in_ready = 1'b0;
    if (accept_en) begin
      if (in_fence)         in_ready = !full1 && !full2;
      else if (in_core_sel) in_ready = !full2;
      else                  in_ready = !full1;
    end
  end

  assign accept   = in_valid && in_ready;
  assign push1    = accept && (in_fence || !in_core_sel);
  assign push2    = accept && (in_fence ||  in_core_sel);
  assign wr_entry = make_entry(in_fence, in_instr);

  // A fence head hides the core's valid until the other queue also reaches
  // its fence; then both fences leave together.
  assign core1_valid  = !empty1 && !head1.fence;
  assign core2_valid  = !empty2 && !head2.fence;
  assign core1_instr  = head1.instr;
  assign core2_instr  = head2.instr;
  assign fence_retire = !empty1 && !empty2 && head1.fence && head2.fence;
  assign pop1         = (core1_valid && core1_ready) || fence_retire;
  assign pop2         = (core2_valid && core2_ready) || fence_retire;

  always_ff @(posedge clk) begin
    if (reset) fence_done <= 1'b0;
    else       fence_done <= fence_retire;
  end

  instr_fifo u_q1 (
    .clk     (clk),
    .reset   (reset),
    .push    (push1),
    .wr_data (wr_entry),
    .pop     (pop1),
    .head    (head1),
    .count   (count1),
    .full    (full1),
    .empty   (empty1)
  );

  instr_fifo u_q2 (
    .clk     (clk),
    .reset   (reset),
    .push    (push2),
    .wr_data (wr_entry),
    .pop     (pop2),
    .head    (head2),
    .count   (count2),
    .full    (full2),
    .empty   (empty2)
  );

endmodule
